// File: rtl/tmds_channel_decoder.sv
// TMDS receive channel: word-alignment hunt via bit-slip on control-token runs, then token/data decode.
// Define TMDS_TERC4_EN to add the TERC4 aux decode (oAuxValid/oAux).
module tmds_channel_decoder #(
    parameter int pTokenRun    = 8,
    parameter int pSearchLimit = 1024,
    parameter int pSlipWait    = 4
) (
    input  logic       iCLK,
    input  logic       iRST,
    input  logic [9:0] iTmds,
    output logic       oBitSlip,
    output logic       oLocked,
    output logic [3:0] oSlipCount,
    output logic       oVde,
    output logic [7:0] oData,
    output logic [1:0] oCtrl
`ifdef TMDS_TERC4_EN
    ,
    output logic       oAuxValid,
    output logic [3:0] oAux
`endif
);

    localparam int RW = $clog2(pTokenRun + 1);
    localparam int GW = (pSearchLimit > 2) ? $clog2(pSearchLimit) : 1;
    localparam int WW = (pSlipWait > 1) ? $clog2(pSlipWait) : 1;
    localparam logic [RW-1:0] RUN_MAX   = RW'(pTokenRun);
    localparam logic [GW-1:0] GAP_LAST  = GW'(pSearchLimit - 1);
    localparam logic [WW-1:0] WAIT_LAST = WW'(pSlipWait - 1);

    typedef enum logic [1:0] {SEARCH, SLIP_WAIT, LOCKED} state_t;

    function automatic logic [2:0] token_of(input logic [9:0] w);
        case (w)
            10'b1101010100: return 3'b100;
            10'b0010101011: return 3'b101;
            10'b0101010100: return 3'b110;
            10'b1010101011: return 3'b111;
            default:        return 3'b000;
        endcase
    endfunction

    // Stage 1: register the word and classify it
    logic [9:0] q1;
    logic       tok1;
    logic [1:0] tok_val1;
    logic       terc1;

    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            q1       <= '0;
            tok1     <= 1'b0;
            tok_val1 <= '0;
        end else begin
            q1               <= iTmds;
            {tok1, tok_val1} <= token_of(iTmds);
        end
    end

`ifdef TMDS_TERC4_EN
    function automatic logic [4:0] terc_of(input logic [9:0] w);
        case (w)
            10'b1010011100: return 5'h10;
            10'b1001100011: return 5'h11;
            10'b1011100100: return 5'h12;
            10'b1011100010: return 5'h13;
            10'b0101110001: return 5'h14;
            10'b0100011110: return 5'h15;
            10'b0110001110: return 5'h16;
            10'b0100111100: return 5'h17;
            10'b1011001100: return 5'h18;
            10'b0100111001: return 5'h19;
            10'b0110011100: return 5'h1a;
            10'b1011000110: return 5'h1b;
            10'b1010001110: return 5'h1c;
            10'b1001110001: return 5'h1d;
            10'b0101100011: return 5'h1e;
            10'b1011000011: return 5'h1f;
            default:        return 5'h00;
        endcase
    endfunction

    logic [3:0] terc_val1;

    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            terc1     <= 1'b0;
            terc_val1 <= '0;
        end else begin
            {terc1, terc_val1} <= terc_of(iTmds);
        end
    end
`else
    assign terc1 = 1'b0;
`endif

    logic [7:0] d, dec;

    always_comb begin
        d      = q1[9] ? ~q1[7:0] : q1[7:0];
        dec    = '0;
        dec[0] = d[0];
        for (int i = 1; i < 8; i++)
            dec[i] = q1[8] ? (d[i] ^ d[i-1]) : ~(d[i] ^ d[i-1]);
    end

    state_t        state;
    logic [RW-1:0] run_cnt, run_inc;
    logic [GW-1:0] gap_cnt;
    logic [WW-1:0] wait_cnt;
    logic          gap_hit, lock_hit, lose, locked_nx;

    assign run_inc  = (run_cnt == RUN_MAX) ? run_cnt : run_cnt + 1'b1;
    assign gap_hit  = (gap_cnt == GAP_LAST);
    assign lock_hit = tok1 && (run_inc >= RUN_MAX);
    assign lose     = !tok1 && !terc1 && gap_hit;
    // Output stage and oLocked both follow the state being entered, so they switch together
    assign locked_nx = (state == LOCKED) ? !lose : ((state == SEARCH) && lock_hit);

    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            state      <= SEARCH;
            run_cnt    <= '0;
            gap_cnt    <= '0;
            wait_cnt   <= '0;
            oBitSlip   <= 1'b0;
            oLocked    <= 1'b0;
            oSlipCount <= '0;
        end else begin
            oBitSlip <= 1'b0;
            oLocked  <= locked_nx;
            case (state)
                SEARCH: begin
                    if (tok1) begin
                        gap_cnt <= '0;
                        run_cnt <= run_inc;
                        if (lock_hit) state <= LOCKED;
                    end else if (gap_hit) begin
                        oBitSlip   <= 1'b1;
                        oSlipCount <= (oSlipCount == 4'd9) ? 4'd0 : oSlipCount + 4'd1;
                        run_cnt    <= '0;
                        gap_cnt    <= '0;
                        wait_cnt   <= '0;
                        state      <= SLIP_WAIT;
                    end else begin
                        gap_cnt <= gap_cnt + 1'b1;
                        if (!terc1) run_cnt <= '0;
                    end
                end
                SLIP_WAIT: begin
                    if (wait_cnt == WAIT_LAST) begin
                        run_cnt <= '0;
                        gap_cnt <= '0;
                        state   <= SEARCH;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                LOCKED: begin
                    if (tok1) begin
                        gap_cnt <= '0;
                        run_cnt <= run_inc;
                    end else if (terc1) begin
                        gap_cnt <= '0;
                    end else if (gap_hit) begin
                        // Losing lock does not slip; SEARCH starts a fresh gap window
                        run_cnt <= '0;
                        gap_cnt <= '0;
                        state   <= SEARCH;
                    end else begin
                        gap_cnt <= gap_cnt + 1'b1;
                        run_cnt <= '0;
                    end
                end
                default: state <= SEARCH;
            endcase
        end
    end

    // Stage 2: decoded outputs
    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            oVde  <= 1'b0;
            oData <= '0;
            oCtrl <= '0;
        end else if (!locked_nx) begin
            oVde  <= 1'b0;
            oData <= '0;
            oCtrl <= '0;
        end else if (tok1) begin
            oVde  <= 1'b0;
            oData <= '0;
            oCtrl <= tok_val1;
        end else if (terc1) begin
            oVde  <= 1'b0;
            oData <= '0;
        end else begin
            oVde  <= 1'b1;
            oData <= dec;
        end
    end

`ifdef TMDS_TERC4_EN
    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            oAuxValid <= 1'b0;
            oAux      <= '0;
        end else begin
            oAuxValid <= locked_nx && terc1;
            oAux      <= (locked_nx && terc1) ? terc_val1 : 4'd0;
        end
    end
`endif

endmodule

// File: tb/tb_tmds_channel_decoder.sv
// Scoreboard bench for tmds_channel_decoder: driver pushes expected outputs, monitor pops and compares.
module tb_tmds_channel_decoder;

    localparam int LIM  = 1024;
    localparam int WAIT = 4;
    localparam int K_DC = 0, K_UNLOCKED = 1, K_LOCKED = 2;

    typedef struct {
        int         kind;
        logic       vde;
        logic [7:0] data;
        logic [1:0] ctrl;
    } exp_t;

    logic       clk, rst;
    logic [9:0] tmds;
    logic       bit_slip, locked, vde;
    logic [3:0] slip_count;
    logic [7:0] data;
    logic [1:0] ctrl;

    tmds_channel_decoder #(.pTokenRun(8), .pSearchLimit(LIM), .pSlipWait(WAIT)) dut (
        .iCLK(clk), .iRST(rst), .iTmds(tmds),
        .oBitSlip(bit_slip), .oLocked(locked), .oSlipCount(slip_count),
        .oVde(vde), .oData(data), .oCtrl(ctrl)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [9:0] tok [4] = '{10'b1101010100, 10'b0010101011, 10'b0101010100, 10'b1010101011};

    exp_t       sbq[$];
    int         compared = 0, mismatched = 0;
    int         cyc = 0, last_push_cyc = 0;
    int         slips = 0, last_slip = -1, first_slip_cyc = -1, off = 0;
    logic [1:0] last_ctrl = 2'b00;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        compared++;
        if (act !== want) begin
            mismatched++;
            $display("FAIL %s @cyc %0d: got %0h, want %0h", name, cyc, act, want);
        end
    endtask

    function automatic int tok_idx(input logic [9:0] w);
        for (int i = 0; i < 4; i++) if (tok[i] == w) return i;
        return -1;
    endfunction

    // Reference: invert the TMDS encoder by searching for the byte that encodes to q
    function automatic logic [9:0] encode(input logic [7:0] b, input logic xor_mode, input logic inv);
        logic [7:0] qm;
        qm[0] = b[0];
        for (int i = 1; i < 8; i++) qm[i] = xor_mode ? (qm[i-1] ^ b[i]) : ~(qm[i-1] ^ b[i]);
        return {inv, xor_mode, inv ? ~qm : qm};
    endfunction

    function automatic logic [7:0] ref_decode(input logic [9:0] q);
        for (int b = 0; b < 256; b++) if (encode(8'(b), q[8], q[9]) == q) return 8'(b);
        return 8'h00;
    endfunction

    function automatic logic [9:0] rand_data();
        logic [9:0] w;
        do w = 10'($urandom); while (tok_idx(w) >= 0);
        return w;
    endfunction

    function automatic logic [9:0] rot(input logic [9:0] w, input int o);
        logic [19:0] dd;
        dd = {w, w};
        return dd[o +: 10];
    endfunction

    task automatic drive(input logic [9:0] w, input int kind);
        exp_t e;
        int   t;
        @(negedge clk);
        tmds   = w;
        e.kind = kind;
        e.vde  = 1'b0;
        e.data = 8'h00;
        e.ctrl = 2'b00;
        if (kind == K_LOCKED) begin
            t = tok_idx(w);
            if (t >= 0) begin
                e.ctrl    = t[1:0];
                last_ctrl = t[1:0];
            end else begin
                e.vde  = 1'b1;
                e.data = ref_decode(w);
                e.ctrl = last_ctrl;
            end
        end
        last_push_cyc = cyc;
        sbq.push_back(e);
    endtask

    task automatic apply_reset();
        #3;
        rst = 1'b1;
        foreach (sbq[i]) sbq[i].kind = K_DC;
        slips = 0; last_slip = -1; first_slip_cyc = -1; off = 0;
        #1;
        chk("reset_outputs", 32'({bit_slip, locked, slip_count, vde, data, ctrl}), 32'h0);
        repeat (3) drive(10'h000, K_DC);
        rst = 1'b0;
    endtask

    task automatic lock_up();
        for (int i = 0; i < 8; i++) drive(tok[0], (i == 7) ? K_LOCKED : K_UNLOCKED);
    endtask

    // Monitor: slip tracking, unlocked-zero rule, scoreboard pop at fixed 2-cycle latency
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            cyc++;
            #1;
            if (bit_slip) begin
                slips++;
                if (slips == 1) first_slip_cyc = cyc;
                if (last_slip >= 0) chk("slip_spacing_ok", 32'(cyc - last_slip >= LIM + WAIT), 32'd1);
                chk("slip_count", 32'(slip_count), 32'(slips % 10));
                last_slip = cyc;
                off = (off == 0) ? 9 : off - 1;
            end
            if (!rst && !locked) chk("unlocked_zero", 32'({vde, data, ctrl}), 32'h0);
            if (sbq.size() >= 2) begin
                e = sbq.pop_front();
                if (e.kind == K_LOCKED)
                    chk("locked_out", 32'({locked, vde, data, ctrl}), 32'({1'b1, e.vde, e.data, e.ctrl}));
                else if (e.kind == K_UNLOCKED)
                    chk("expect_unlocked", 32'(locked), 32'd0);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int n, p;
        rst  = 1'b1;
        tmds = 10'h000;
        apply_reset();

        // Lock on 8 tokens, then fixed decode cases and random locked traffic
        lock_up();
        drive(tok[0], K_LOCKED);
        drive(10'b0100000000, K_LOCKED);
        drive(10'b1011111111, K_LOCKED);
        drive(tok[3], K_LOCKED);
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 3) == 0) drive(tok[$urandom_range(0, 3)], K_LOCKED);
            else drive(rand_data(), K_LOCKED);
        end
        chk("no_slip_while_locking", 32'(slips), 32'd0);

        // Loss of lock at the 1024th data word; first slip after a further 1024
        drive(tok[1], K_LOCKED);
        for (int j = 1; j <= 1024; j++) drive(rand_data(), (j < 1024) ? K_LOCKED : K_UNLOCKED);
        for (int j = 1025; j <= 2048; j++) drive(rand_data(), K_UNLOCKED);
        p = last_push_cyc;
        repeat (2) drive(rand_data(), K_UNLOCKED);
        chk("slips_after_loss", 32'(slips), 32'd1);
        chk("slip_after_loss_cyc", 32'(first_slip_cyc), 32'(p + 2));

        // Misaligned token stream: each slip moves the window by one bit
        apply_reset();
        off = 3;
        n = 0;
        while (!locked && n < 5000) begin
            drive(rot(tok[0], off), K_DC);
            n++;
        end
        chk("misalign_locked", 32'(locked), 32'd1);
        chk("misalign_slips", 32'(slips), 32'd3);
        chk("misalign_slip_count", 32'(slip_count), 32'd3);

        // Unalignable input: 10 slips wrap the counter
        apply_reset();
        n = 0;
        while (slips < 10 && n < 12000) begin
            drive(rand_data(), K_UNLOCKED);
            n++;
        end
        chk("wrap_slips", 32'(slips), 32'd10);
        chk("wrap_slip_count", 32'(slip_count), 32'd0);
        chk("wrap_not_locked", 32'(locked), 32'd0);

        // Reset while locked, then while a slip pulse is high
        apply_reset();
        lock_up();
        repeat (5) drive(rand_data(), K_LOCKED);
        chk("pre_reset_locked", 32'(locked), 32'd1);
        apply_reset();
        n = 0;
        while (!bit_slip && n < 1200) begin
            drive(rand_data(), K_UNLOCKED);
            n++;
        end
        chk("slip_pending", 32'(bit_slip), 32'd1);
        apply_reset();
        lock_up();
        repeat (5) drive(rand_data(), K_LOCKED);
        drive(tok[2], K_LOCKED);
        repeat (3) drive(tok[2], K_DC);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
